// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing scheduler.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mul_share_sched_rr_pick.sv
// Combinational round-robin select: first asserted request strictly after
// rr_ptr, wrapping modulo NREQ.
module rr_pick import mul_share_pkg::*; #(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one sequential multiplier among NREQ clients.
// Optional: define MUL_SHARE_ZERO_BYPASS_EN to skip the multiplier on a zero operand.
module mul_share_sched import mul_share_pkg::*; #(
    parameter int n    = 8,
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*n-1:0]        op_a,
    input  logic [NREQ*n-1:0]        op_b,
    output logic [NREQ-1:0]          done,
    output logic [clog2(NREQ)-1:0]   gnt_id,
    output logic                     busy,
    output logic [2*n-1:0]           product,
    output logic                     m_req,
    output logic [n-1:0]             m_a,
    output logic [n-1:0]             m_b,
    input  logic                     m_ack,
    input  logic [2*n-1:0]           m_p
);

    localparam int IW = clog2(NREQ);

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic [n-1:0]    m_a_q, m_a_d;
    logic [n-1:0]    m_b_q, m_b_d;
    logic [2*n-1:0]  product_q, product_d;
    logic            m_req_q, m_req_d;
    logic            busy_q, busy_d;

    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic [n-1:0]    sel_a, sel_b;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    assign sel_a = op_a[int'(pick_idx)*n +: n];
    assign sel_b = op_b[int'(pick_idx)*n +: n];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_id_d  = gnt_id_q;
        m_a_d     = m_a_q;
        m_b_d     = m_b_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_id_d = pick_idx;
                    rr_ptr_d = pick_idx;
                    m_a_d    = sel_a;
                    m_b_d    = sel_b;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
                    if (sel_a == '0 || sel_b == '0) begin
                        product_d = '0;
                        state_d   = DONE;
                    end else begin
                        state_d   = ISSUE;
                    end
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (m_ack) begin
                    product_d = m_p;
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
        endcase
        // Start pulse and busy are registered off the next state so they align with it.
        m_req_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= IW'(NREQ - 1);
            gnt_id_q  <= '0;
            m_a_q     <= '0;
            m_b_q     <= '0;
            product_q <= '0;
            m_req_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_id_q  <= gnt_id_d;
            m_a_q     <= m_a_d;
            m_b_q     <= m_b_d;
            product_q <= product_d;
            m_req_q   <= m_req_d;
            busy_q    <= busy_d;
        end
    end

    assign done    = (state_q == DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_id_q) : '0;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign product = product_q;
    assign m_req   = m_req_q;
    assign m_a     = m_a_q;
    assign m_b     = m_b_q;

endmodule

// File: tb/tb_mul_share_sched.sv
// Self-checking bench: transaction-level scheduler model plus a latency-programmable multiplier.
module tb_mul_share_sched;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IW   = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*N-1:0]   op_a = '0;
    logic [NREQ*N-1:0]   op_b = '0;
    logic [NREQ-1:0]     done;
    logic [IW-1:0]       gnt_id;
    logic                busy;
    logic [2*N-1:0]      product;
    logic                m_req;
    logic [N-1:0]        m_a, m_b;
    logic                m_ack = 1'b0;
    logic [2*N-1:0]      m_p = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_share_sched #(.n(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
        .done(done), .gnt_id(gnt_id), .busy(busy), .product(product),
        .m_req(m_req), .m_a(m_a), .m_b(m_b), .m_ack(m_ack), .m_p(m_p)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (operation-level) ----------------
    bit             mo_have = 0, mo_in_done = 0, mo_found, mo_byp;
    int             mo_ptr = NREQ - 1, mo_age = 0, mo_w;
    logic [IW-1:0]  mo_own = '0;
    logic [N-1:0]   mo_a = '0, mo_b = '0;
    logic [2*N-1:0] mo_prod = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mo_have = 0; mo_in_done = 0; mo_ptr = NREQ - 1; mo_age = 0;
                mo_own = '0; mo_a = '0; mo_b = '0; mo_prod = '0;
            end else if (!mo_have) begin
                mo_found = 0;
                mo_w = 0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!mo_found && req[(mo_ptr + k) % NREQ]) begin
                        mo_found = 1;
                        mo_w = (mo_ptr + k) % NREQ;
                    end
                end
                if (mo_found) begin
                    mo_have = 1;
                    mo_age  = 1;
                    mo_ptr  = mo_w;
                    mo_own  = mo_w[IW-1:0];
                    mo_a    = op_a[mo_w*N +: N];
                    mo_b    = op_b[mo_w*N +: N];
`ifdef MUL_SHARE_ZERO_BYPASS_EN
                    mo_byp = (mo_a == 0 || mo_b == 0);
`else
                    mo_byp = 0;
`endif
                    if (mo_byp) begin
                        mo_in_done = 1;
                        mo_prod = '0;
                    end
                end
            end else if (mo_in_done) begin
                mo_have = 0;
                mo_in_done = 0;
            end else begin
                if (mo_age >= 2 && m_ack) begin
                    mo_in_done = 1;
                    mo_prod = {8'b0, mo_a} * {8'b0, mo_b};
                end
                mo_age++;
            end
        end
    end

    // Compare every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("busy", busy, mo_have);
            chk("m_req", m_req, mo_have && !mo_in_done && mo_age == 1);
            chk("done", done, mo_in_done ? (32'd1 << mo_own) : 32'd0);
            chk("gnt_id", gnt_id, mo_own);
            chk("product", product, mo_prod);
            chk("m_a", m_a, mo_a);
            chk("m_b", m_b, mo_b);
            chk("done_onehot0", $onehot0(done), 1);
        end
    end

    // ---------------- stimulus: requesters + multiplier ----------------
    int             mcnt = 0, fixed_lat = 10, nmreq = 0;
    bit             rand_mode = 0, noise = 0, rand_lat = 0;
    logic [NREQ-1:0] rereq = '0;
    logic [2*N-1:0] mprod = '0;

    task automatic step();
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        m_p   = 16'($urandom());
        if (!rst_n) begin
            mcnt = 0;
        end else begin
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    m_ack = 1'b1;
                    m_p   = mprod;
                end
            end
            if (m_req) begin
                nmreq++;
                mcnt  = rand_lat ? $urandom_range(6, 1) : fixed_lat;
                mprod = {8'b0, m_a} * {8'b0, m_b};
            end
            if (!m_ack && mcnt == 0 && !m_req && noise && (!busy || done != 0) &&
                $urandom_range(3) == 0)
                m_ack = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (done[i])
                req[i] = rand_mode ? 1'($urandom_range(1)) : rereq[i];
            else if (rand_mode && !req[i] && $urandom_range(2) == 0)
                req[i] = 1'b1;
            if (rand_mode) begin
                op_a[i*N +: N] = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom());
                op_b[i*N +: N] = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom());
            end
        end
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (done == 0 && cyc < maxc);
        if (done == 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done within %0d cycles", maxc);
        end
    endtask

    task automatic do_reset();
        req = '0; rand_mode = 0; noise = 0; rand_lat = 0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic int ohid(input logic [NREQ-1:0] d);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (d[i]) r = i;
        return r;
    endfunction

    int c;
    int exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        // reset state
        step();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_prod", product, 0);

        // single request, fixed latency 10
        do_reset();
        fixed_lat = 10; rereq = '0; nmreq = 0;
        op_a[0 +: N] = 8'd3; op_b[0 +: N] = 8'd5; req = 4'b0001;
        wait_done(40, c);
        chk("t1_latency", c, 12);
        chk("t1_done", done, 4'b0001);
        chk("t1_prod", product, 15);
        step();
        chk("t1_done_1cyc", done, 0);
        chk("t1_busy_low", busy, 0);
        chk("t1_mreq_cnt", nmreq, 1);

        // contention after reset
        do_reset();
        op_a[0 +: N] = 8'd7;  op_b[0 +: N] = 8'd9;
        op_a[16 +: N] = 8'd11; op_b[16 +: N] = 8'd13;
        req = 4'b0101;
        wait_done(40, c);
        chk("t2_first", done, 4'b0001);
        chk("t2_prod0", product, 63);
        wait_done(40, c);
        chk("t2_second", done, 4'b0100);
        chk("t2_prod2", product, 143);

        // fairness with continuous re-request
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*N +: N] = 8'(i + 2);
            op_b[i*N +: N] = 8'(i + 5);
        end
        rereq = 4'hF; req = 4'hF; fixed_lat = 3;
        for (int k = 0; k < 5; k++) begin
            wait_done(40, c);
            chk("t3_order", ohid(done), exp_ord[k]);
        end

        // width corner
        do_reset();
        rereq = '0;
        op_a[0 +: N] = 8'd255; op_b[0 +: N] = 8'd255; req = 4'b0001;
        wait_done(40, c);
        chk("t4_prod", product, 16'hFE01);

        // reset mid-WAIT of requester 1's operation
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*N +: N] = 8'(i + 2);
            op_b[i*N +: N] = 8'(i + 5);
        end
        rereq = 4'hF; req = 4'hF; fixed_lat = 10;
        wait_done(40, c);
        step(); step(); step();
        chk("t5_pre_busy", busy, 1);
        chk("t5_pre_gnt", gnt_id, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy0", busy, 0);
        chk("t5_gnt0", gnt_id, 0);
        chk("t5_prod0", product, 0);
        chk("t5_ma0", m_a, 0);
        chk("t5_mb0", m_b, 0);
        chk("t5_done0", done, 0);
        chk("t5_mreq0", m_req, 0);
        step(); step();
        rst_n = 1'b1;
        wait_done(40, c);
        chk("t5_first_after", ohid(done), 0);

        // zero operand
        do_reset();
        rereq = '0; fixed_lat = 10;
        op_a[8 +: N] = 8'd3; op_b[8 +: N] = 8'd5; req = 4'b0010;
        wait_done(40, c);
        chk("t6_pre_prod", product, 15);
        step();
        op_a[8 +: N] = 8'd0; op_b[8 +: N] = 8'd77; req = 4'b0010; nmreq = 0;
        wait_done(40, c);
        chk("t6_done", done, 4'b0010);
        chk("t6_prod", product, 0);
`ifdef MUL_SHARE_ZERO_BYPASS_EN
        chk("t6_latency", c, 1);
        chk("t6_mreq_cnt", nmreq, 0);
`else
        chk("t6_latency", c, 12);
        chk("t6_mreq_cnt", nmreq, 1);
`endif

        // randomized traffic with spurious acks and random latency
        do_reset();
        rand_mode = 1; noise = 1; rand_lat = 1;
        for (int k = 0; k < 3000; k++) step();
        rand_mode = 0; req = '0;
        for (int k = 0; k < 30; k++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
